// File: rtl/charram_dram_ctrl.sv
// Character-RAM DRAM controller: arbitrates a pulsed video fetch port and a
// level-request CPU port onto one multiplexed-address DRAM, one access per slot.
module charram_dram_ctrl #(
    parameter int ACC_CYCLES = 2,
    parameter int PRE_CYCLES = 1
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    output logic        o_VID_OVR,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WR,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_DRAM_ADDR,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n,
    output logic        o_BUSY
);

    typedef enum logic [2:0] {IDLE, ROW, COL, ACC, DONE, PRE} state_t;

    localparam logic [1:0] ACC_LAST = 2'(ACC_CYCLES - 1);
    localparam logic [1:0] PRE_LAST = 2'(PRE_CYCLES - 1);

    state_t      state, nstate;
    logic [1:0]  cnt;

    // single-entry video pending slot
    logic        vid_pend;
    logic [13:0] vid_paddr;

    // CPU must drop its request between accesses; cpu_lost drives alternation
    logic        cpu_rearm;
    logic        cpu_lost;

    // access latched at grant
    logic        cur_cpu;
    logic        cur_wr;
    logic [13:0] cur_addr;
    logic [3:0]  cur_din;

    logic        vid_elig, cpu_elig, grant, grant_cpu;
    logic [13:0] gaddr;

    // Next-state and arbitration; grants only happen out of IDLE
    always_comb begin
        vid_elig  = vid_pend;
        cpu_elig  = i_CPU_REQ & cpu_rearm;
        grant     = 1'b0;
        grant_cpu = 1'b0;
        nstate    = state;
        case (state)
            IDLE: if (vid_elig || cpu_elig) begin
                grant     = 1'b1;
                grant_cpu = cpu_elig && (!vid_elig || cpu_lost);
                nstate    = ROW;
            end
            ROW:  nstate = COL;
            COL:  nstate = ACC;
            ACC:  if (cnt == ACC_LAST) nstate = DONE;
            DONE: nstate = PRE;
            PRE:  if (cnt == PRE_LAST) nstate = IDLE;
            default: nstate = IDLE;
        endcase
        gaddr = grant_cpu ? i_CPU_ADDR : vid_paddr;
    end

    // State register plus dwell counter for the multi-cycle ACC/PRE states
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= nstate;
            cnt   <= (nstate == state) ? cnt + 2'd1 : 2'd0;
        end
    end

    // Latch the winning request so later input changes cannot disturb the access
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            cur_cpu  <= 1'b0;
            cur_wr   <= 1'b0;
            cur_addr <= 14'd0;
            cur_din  <= 4'd0;
        end else if (grant) begin
            cur_cpu  <= grant_cpu;
            cur_wr   <= grant_cpu & i_CPU_WR;
            cur_addr <= gaddr;
            cur_din  <= i_CPU_DIN;
        end
    end

    // Video slot: a pulse fills it; a pulse arriving while it is already full
    // and not being granted this cycle overwrites the address and flags overrun
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            vid_pend  <= 1'b0;
            vid_paddr <= 14'd0;
            o_VID_OVR <= 1'b0;
        end else begin
            o_VID_OVR <= i_VID_REQ && vid_pend && !(grant && !grant_cpu);
            if (grant && !grant_cpu) vid_pend <= 1'b0;
            if (i_VID_REQ) begin
                vid_pend  <= 1'b1;
                vid_paddr <= i_VID_ADDR;
            end
        end
    end

    // CPU re-arm and contested-arbitration history
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            cpu_rearm <= 1'b1;
            cpu_lost  <= 1'b0;
        end else begin
            if (!i_CPU_REQ)     cpu_rearm <= 1'b1;
            else if (o_CPU_ACK) cpu_rearm <= 1'b0;
            if (grant && vid_elig && cpu_elig) cpu_lost <= !grant_cpu;
        end
    end

    // Registered DRAM strobes/address and completion strobes, driven from nstate
    // so every output lines up with the state it belongs to
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            o_RAS_n     <= 1'b1;
            o_CAS_n     <= 1'b1;
            o_WR_n      <= 1'b1;
            o_RD_n      <= 1'b1;
            o_DRAM_ADDR <= 8'd0;
            o_DRAM_DIN  <= 4'd0;
            o_VID_DATA  <= 4'd0;
            o_CPU_DOUT  <= 4'd0;
            o_VID_VALID <= 1'b0;
            o_CPU_ACK   <= 1'b0;
            o_BUSY      <= 1'b0;
        end else begin
            o_VID_VALID <= 1'b0;
            o_CPU_ACK   <= 1'b0;
            o_BUSY      <= (nstate != IDLE);
            case (nstate)
                ROW: begin
                    o_DRAM_ADDR <= gaddr[7:0];
                    o_RAS_n     <= 1'b0;
                    o_CAS_n     <= 1'b1;
                    o_WR_n      <= 1'b1;
                    o_RD_n      <= 1'b1;
                end
                COL: begin
                    o_DRAM_ADDR <= {1'b0, cur_addr[13:8], 1'b0};
                    o_RAS_n     <= 1'b0;
                    o_CAS_n     <= 1'b0;
                end
                ACC: begin
                    o_RAS_n <= 1'b0;
                    o_CAS_n <= 1'b0;
                    o_RD_n  <= cur_wr;
                    o_WR_n  <= !cur_wr;
                    if (cur_wr) o_DRAM_DIN <= cur_din;
                end
                DONE: begin
                    o_RAS_n <= 1'b0;
                    o_CAS_n <= 1'b0;
                    o_RD_n  <= 1'b1;
                    o_WR_n  <= 1'b1;
                    if (cur_cpu) begin
                        o_CPU_ACK <= 1'b1;
                        if (!cur_wr) o_CPU_DOUT <= i_DRAM_DOUT;
                    end else begin
                        o_VID_VALID <= 1'b1;
                        o_VID_DATA  <= i_DRAM_DOUT;
                    end
                end
                default: begin
                    o_RAS_n <= 1'b1;
                    o_CAS_n <= 1'b1;
                    o_WR_n  <= 1'b1;
                    o_RD_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl with a small registered DRAM model.
module tb_charram_dram_ctrl;

    logic        i_MCLK = 1'b0;
    logic        i_RST = 1'b0;
    logic        i_VID_REQ = 1'b0;
    logic [13:0] i_VID_ADDR = 14'd0;
    logic [3:0]  o_VID_DATA;
    logic        o_VID_VALID, o_VID_OVR;
    logic        i_CPU_REQ = 1'b0, i_CPU_WR = 1'b0;
    logic [13:0] i_CPU_ADDR = 14'd0;
    logic [3:0]  i_CPU_DIN = 4'd0;
    logic [3:0]  o_CPU_DOUT;
    logic        o_CPU_ACK;
    logic [7:0]  o_DRAM_ADDR;
    logic [3:0]  o_DRAM_DIN;
    logic [3:0]  dram_dout = 4'd0;
    logic        o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_BUSY;

    charram_dram_ctrl dut (
        .i_MCLK(i_MCLK), .i_RST(i_RST),
        .i_VID_REQ(i_VID_REQ), .i_VID_ADDR(i_VID_ADDR),
        .o_VID_DATA(o_VID_DATA), .o_VID_VALID(o_VID_VALID), .o_VID_OVR(o_VID_OVR),
        .i_CPU_REQ(i_CPU_REQ), .i_CPU_WR(i_CPU_WR), .i_CPU_ADDR(i_CPU_ADDR),
        .i_CPU_DIN(i_CPU_DIN), .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK),
        .o_DRAM_ADDR(o_DRAM_ADDR), .o_DRAM_DIN(o_DRAM_DIN), .i_DRAM_DOUT(dram_dout),
        .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n), .o_RD_n(o_RD_n),
        .o_BUSY(o_BUSY)
    );

    always #5 i_MCLK = ~i_MCLK;

    // DRAM model: row latched in ROW, registered read data, contents default
    // to addr[3:0]^addr[7:4] (so 14'h2A5C holds 4'h9, 14'h1111 holds 4'h0)
    logic [3:0] mem [0:16383];
    logic [7:0] row_q = 8'd0;
    logic       mem_init = 1'b0;
    always @(posedge i_MCLK) begin
        if (i_RST && !mem_init) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 4'(i) ^ 4'(i >> 4);
            mem_init <= 1'b1;
        end
        if (!o_RAS_n && o_CAS_n) row_q <= o_DRAM_ADDR;
        if (!o_CAS_n && !o_RD_n) dram_dout <= mem[{o_DRAM_ADDR[6:1], row_q}];
        if (!o_CAS_n && !o_WR_n) mem[{o_DRAM_ADDR[6:1], row_q}] <= o_DRAM_DIN;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_MCLK);
        #1;
    endtask

    int  n_ack, n_row, n_wr, n_ovr, n_val;
    int  row_t[$];
    byte who[$];
    logic prev_ras, got;
    logic [7:0] vrow;
    logic [3:0] vdat;

    initial begin
        // ---- reset values
        #2 i_RST = 1'b1;
        #2;
        chk("rst_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
        chk("rst_addr_din", {o_DRAM_ADDR, o_DRAM_DIN}, 12'h000);
        chk("rst_data", {o_VID_DATA, o_CPU_DOUT}, 8'h00);
        chk("rst_pulses", {o_VID_VALID, o_VID_OVR, o_CPU_ACK, o_BUSY}, 4'h0);
        repeat (2) tick();
        i_RST = 1'b0;
        tick();
        chk("idle_busy", o_BUSY, 1'b0);

        // ---- single video fetch of 14'h2A5C
        i_VID_REQ = 1'b1; i_VID_ADDR = 14'h2A5C;
        tick();
        i_VID_REQ = 1'b0;
        chk("v_slot_idle", {o_RAS_n, o_BUSY}, 2'b10);
        tick();
        chk("v_row", {o_RAS_n, o_CAS_n, o_DRAM_ADDR}, {2'b01, 8'h5C});
        chk("v_row_busy", o_BUSY, 1'b1);
        tick();
        chk("v_col", {o_RAS_n, o_CAS_n, o_RD_n, o_DRAM_ADDR}, {3'b001, 8'h54});
        tick();
        chk("v_acc1", {o_CAS_n, o_RD_n, o_WR_n, o_DRAM_ADDR}, {3'b001, 8'h54});
        tick();
        chk("v_acc2", {o_CAS_n, o_RD_n, o_WR_n}, 3'b001);
        tick();
        chk("v_done", {o_RAS_n, o_CAS_n, o_RD_n, o_VID_VALID, o_VID_DATA}, {4'b0011, 4'h9});
        tick();
        chk("v_pre", {o_RAS_n, o_CAS_n, o_RD_n, o_WR_n, o_VID_VALID, o_BUSY}, 6'b111101);
        chk("v_data_hold", o_VID_DATA, 4'h9);
        tick();
        chk("v_back_idle", o_BUSY, 1'b0);

        // ---- CPU write 4'hF to 14'h0101, request held; inputs scrambled after grant
        i_CPU_REQ = 1'b1; i_CPU_WR = 1'b1; i_CPU_ADDR = 14'h0101; i_CPU_DIN = 4'hF;
        tick();
        chk("c_row", {o_RAS_n, o_DRAM_ADDR}, {1'b0, 8'h01});
        i_CPU_WR = 1'b0; i_CPU_ADDR = 14'h3FFF; i_CPU_DIN = 4'h0;
        n_ack = 0; n_row = 0; n_wr = 0; prev_ras = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_CPU_ACK) n_ack++;
            if (prev_ras && !o_RAS_n) n_row++;
            prev_ras = o_RAS_n;
            if (!o_CAS_n && o_RAS_n == 1'b0 && o_DRAM_ADDR != 8'h02 && o_CAS_n == 1'b0 && i == 0)
                chk("c_col_addr", o_DRAM_ADDR, 8'h02);
            if (!o_WR_n) begin
                n_wr++;
                chk("c_wr_din", o_DRAM_DIN, 4'hF);
            end
        end
        chk("c_one_ack", n_ack, 1);
        chk("c_no_rearm", n_row, 0);
        chk("c_wr_cycles", n_wr, 2);
        i_CPU_REQ = 1'b0;
        tick();
        // readback
        i_CPU_REQ = 1'b1; i_CPU_WR = 1'b0; i_CPU_ADDR = 14'h0101;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (o_CPU_ACK) got = 1'b1;
        end
        chk("c_rd_ack", got, 1'b1);
        chk("c_rd_data", o_CPU_DOUT, 4'hF);
        i_CPU_REQ = 1'b0;
        repeat (4) tick();
        chk("c_dout_hold", o_CPU_DOUT, 4'hF);

        // ---- both ports requesting continuously: V,C,V,C with 7-cycle slots
        i_VID_REQ = 1'b1; i_VID_ADDR = 14'h0010;
        tick();
        i_VID_REQ = 1'b0;
        i_CPU_REQ = 1'b1; i_CPU_WR = 1'b0; i_CPU_ADDR = 14'h0101;
        prev_ras = 1'b1; n_ovr = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (prev_ras && !o_RAS_n) row_t.push_back(c);
            prev_ras = o_RAS_n;
            if (o_VID_VALID) who.push_back("V");
            if (o_CPU_ACK) who.push_back("C");
            if (o_VID_OVR) n_ovr++;
            i_VID_REQ = o_VID_VALID;
            i_CPU_REQ = !o_CPU_ACK;
        end
        i_VID_REQ = 1'b0; i_CPU_REQ = 1'b0;
        chk("alt_count", (who.size() >= 4 && row_t.size() >= 4), 1'b1);
        if (who.size() >= 4 && row_t.size() >= 4) begin
            chk("alt_seq", {who[0], who[1], who[2], who[3]}, {"V", "C", "V", "C"});
            chk("slot_0", row_t[1] - row_t[0], 7);
            chk("slot_1", row_t[2] - row_t[1], 7);
            chk("slot_2", row_t[3] - row_t[2], 7);
        end
        chk("alt_no_ovr", n_ovr, 0);
        repeat (20) tick();
        chk("alt_drained", o_BUSY, 1'b0);

        // ---- overrun: two video pulses three cycles apart during a CPU read
        i_CPU_REQ = 1'b1; i_CPU_WR = 1'b0; i_CPU_ADDR = 14'h0101;
        tick();
        i_VID_REQ = 1'b1; i_VID_ADDR = 14'h1111;
        tick();
        i_VID_REQ = 1'b0;
        chk("ovr_first_none", o_VID_OVR, 1'b0);
        tick();
        tick();
        i_VID_REQ = 1'b1; i_VID_ADDR = 14'h2A5C;
        n_ovr = 0; n_val = 0; n_row = 0; vrow = 8'h00; vdat = 4'h0;
        prev_ras = o_RAS_n;
        for (int i = 0; i < 20; i++) begin
            tick();
            i_VID_REQ = 1'b0;
            if (o_CPU_ACK) i_CPU_REQ = 1'b0;
            if (o_VID_OVR) n_ovr++;
            if (o_VID_VALID) begin n_val++; vdat = o_VID_DATA; end
            if (prev_ras && !o_RAS_n) begin n_row++; vrow = o_DRAM_ADDR; end
            prev_ras = o_RAS_n;
        end
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_one_fetch", {n_val[3:0], n_row[3:0]}, 8'h11);
        chk("ovr_row", vrow, 8'h5C);
        chk("ovr_data", vdat, 4'h9);

        // ---- reset during ACC of a CPU read
        i_CPU_REQ = 1'b1; i_CPU_WR = 1'b0; i_CPU_ADDR = 14'h0101;
        tick();
        tick();
        tick();
        chk("rst_in_acc", {o_RAS_n, o_CAS_n, o_RD_n}, 3'b000);
        #2 i_RST = 1'b1;
        #1;
        chk("rst_async_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
        chk("rst_async_busy", {o_BUSY, o_CPU_ACK, o_CPU_DOUT}, 6'h00);
        i_CPU_REQ = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_CPU_ACK) n_ack++;
        end
        i_RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_CPU_ACK) n_ack++;
        end
        chk("rst_no_ack", n_ack, 0);
        chk("rst_idle_after", {o_BUSY, o_RAS_n}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/charram_dram_ctrl.md
CHARRAM_DRAM_CTRL -- requirements
Module: charram_dram_ctrl

Interface
REQ-001 SHALL provide parameter ACC_CYCLES, default 2, number of read/write strobe cycles per access (legal 1..4).
REQ-002 SHALL provide parameter PRE_CYCLES, default 1, number of RAS/CAS precharge cycles after each access (legal 1..4).
REQ-003 SHALL have port i_MCLK  in  1  single clock; all logic is on posedge.
REQ-004 SHALL have port i_RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_VID_REQ in 1 (one-cycle fetch pulse) and i_VID_ADDR in 14 (fetch address).
REQ-006 SHALL have ports o_VID_DATA out 4 (fetched nibble), o_VID_VALID out 1 (one-cycle data strobe) and o_VID_OVR out 1 (one-cycle overrun strobe).
REQ-007 SHALL have ports i_CPU_REQ in 1 (level request), i_CPU_WR in 1 (1 = write), i_CPU_ADDR in 14 and i_CPU_DIN in 4.
REQ-008 SHALL have ports o_CPU_DOUT out 4 (read data) and o_CPU_ACK out 1 (one-cycle completion strobe).
REQ-009 SHALL have ports o_DRAM_ADDR out 8 (multiplexed address), o_DRAM_DIN out 4 and i_DRAM_DOUT in 4 (registered DRAM read data).
REQ-010 SHALL have ports o_RAS_n, o_CAS_n, o_WR_n and o_RD_n, each out 1, active-low DRAM strobes.
REQ-011 SHALL have port o_BUSY out 1, high in every state except IDLE.

Function
REQ-012 SHALL register every output; no output is combinational from any input.
REQ-013 SHALL implement FSM states IDLE, ROW, COL, ACC, DONE and PRE.
REQ-014 SHALL sequence IDLE->ROW when any eligible request exists, then ROW->COL->ACC (ACC_CYCLES cycles)->DONE->PRE (PRE_CYCLES cycles)->IDLE; it SHALL arbitrate only in IDLE.
REQ-015 SHALL drive, in ROW, o_DRAM_ADDR = addr[7:0] with o_RAS_n=0 and o_CAS_n=1.
REQ-016 SHALL drive, in COL, o_DRAM_ADDR = {1'b0, addr[13:8], 1'b0} with o_RAS_n=0 and o_CAS_n=0.
REQ-017 SHALL, in ACC, hold o_RAS_n=0, o_CAS_n=0 and the column address, and assert o_RD_n=0 for reads or o_WR_n=0 with o_DRAM_DIN = latched data for writes.
REQ-018 SHALL, in DONE, keep RAS/CAS low, negate RD/WR, capture i_DRAM_DOUT into o_VID_DATA or o_CPU_DOUT (reads only), and pulse o_VID_VALID or o_CPU_ACK for exactly one cycle.
REQ-019 SHALL, in PRE and IDLE, drive all four strobes high.
REQ-020 SHALL give a video read 1+1+ACC_CYCLES+1 = 5 cycles (defaults) of latency from the ROW cycle to o_VID_VALID.
REQ-021 SHALL give a full access slot of 5+PRE_CYCLES cycles, plus one IDLE cycle.
REQ-022 SHALL latch a pulse on i_VID_REQ, with i_VID_ADDR, into a single pending slot; video accesses are always reads.
REQ-023 SHALL, when i_VID_REQ arrives while the pending slot is still ungranted, overwrite the slot address and pulse o_VID_OVR for one cycle.
REQ-024 SHALL accept a new i_VID_REQ while a video access is in flight into the empty pending slot, without overrun.
REQ-025 SHALL treat the CPU request as eligible when i_CPU_REQ=1 and the re-arm flag is set.
REQ-026 SHALL clear the re-arm flag on o_CPU_ACK and set it again on any cycle with i_CPU_REQ=0.
REQ-027 SHALL sample i_CPU_WR, i_CPU_ADDR and i_CPU_DIN at grant (the IDLE->ROW edge); later changes to them SHALL have no effect on the access.
REQ-028 SHALL arbitrate with video priority, except that when the CPU lost the previous contested arbitration the CPU SHALL win, so contested grants strictly alternate.
REQ-029 SHALL, on a simultaneous i_VID_REQ pulse and grant in the same IDLE cycle, see the new pulse in the next arbitration only.
REQ-030 SHALL leave o_CPU_DOUT and o_VID_DATA holding their last captured values between accesses.

Reset
REQ-031 SHALL, while i_RST=1 (asynchronously), force state=IDLE; o_RAS_n, o_CAS_n, o_WR_n and o_RD_n = 1; o_DRAM_ADDR, o_DRAM_DIN, o_VID_DATA and o_CPU_DOUT = 0; o_VID_VALID, o_VID_OVR, o_CPU_ACK and o_BUSY = 0; pending slot empty; re-arm flag = 1; contest flag cleared.
REQ-032 SHALL, on reset mid-access, abort the access with no ACK/VALID; a CPU write aborted in ACC may have partially written the DRAM.

Verification
REQ-033 SHALL be verified by: idle; one-cycle i_VID_REQ, addr 14'h2A5C, DRAM model holding 4'h9 -> ROW addr 8'h5C, COL addr 8'h54, two RD_n low cycles, o_VID_VALID pulse with o_VID_DATA=4'h9.
REQ-034 SHALL be verified by: CPU write, addr 14'h0101, data 4'hF, request held -> exactly one o_CPU_ACK pulse; no second access until i_CPU_REQ drops; a readback returns 4'hF.
REQ-035 SHALL be verified by: video and CPU requesting continuously -> grants alternate V,C,V,C; each slot is 7 cycles including IDLE.
REQ-036 SHALL be verified by: two i_VID_REQ pulses three cycles apart during a CPU access -> one o_VID_OVR pulse, and only the second address is fetched.
REQ-037 SHALL be verified by: i_RST asserted during ACC of a CPU read -> strobes go high without waiting for a clock edge, no ACK, FSM in IDLE after release.
